reduction_stream_engine: RTL and testbench

//  Multi-cycle AND/OR/XOR/popcount reduction over a parametrised wide bus.

---
 rtl/reduction_stream_engine.sv | 150 +++++++++++++++
 tb/tb_reduction_stream_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reduction_stream_engine.sv
// Multi-cycle AND/OR/XOR/popcount reducer over a wide operand bus,
// folding CHUNK_WIDTH bits per cycle behind valid/ready handshakes.
module reduction_stream_engine #(
    parameter int  DATA_WIDTH  = 256,
    parameter int  CHUNK_WIDTH = 64,
    localparam int NUM_CHUNKS  = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH,
    localparam int CNT_W       = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_and,
    output logic                  out_or,
    output logic                  out_xor,
    output logic [CNT_W-1:0]      out_popcount
);
    localparam int PAD_W  = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int LAST_W = DATA_WIDTH - (NUM_CHUNKS - 1) * CHUNK_WIDTH;
    localparam int IDX_W  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CHUNK_WIDTH-1:0] LAST_MASK =
        {CHUNK_WIDTH{1'b1}} >> (CHUNK_WIDTH - LAST_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PAD_W-1:0] sr_q, sr_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             acc_and_q, acc_and_d;
    logic             acc_or_q, acc_or_d;
    logic             acc_xor_q, acc_xor_d;
    logic [CNT_W-1:0] acc_pop_q, acc_pop_d;
    logic             res_and_q, res_and_d;
    logic             res_or_q, res_or_d;
    logic             res_xor_q, res_xor_d;
    logic [CNT_W-1:0] res_pop_q, res_pop_d;

    logic [CHUNK_WIDTH-1:0] chunk;
    logic [CHUNK_WIDTH-1:0] mask;
    logic [CNT_W-1:0]       chunk_pop;
    logic                   last;
    logic                   fold_and, fold_or, fold_xor;
    logic [CNT_W-1:0]       fold_pop;

    // Padding above DATA_WIDTH is zero in the shift register, so only AND
    // needs the mask to see pad bits as ones.
    always_comb begin
        chunk     = sr_q[CHUNK_WIDTH-1:0];
        last      = (cnt_q == LAST_IDX);
        mask      = last ? LAST_MASK : {CHUNK_WIDTH{1'b1}};
        chunk_pop = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            chunk_pop = chunk_pop + CNT_W'(chunk[i]);
        end
        fold_and = acc_and_q & (&(chunk | ~mask));
        fold_or  = acc_or_q | (|chunk);
        fold_xor = acc_xor_q ^ (^chunk);
        fold_pop = acc_pop_q + chunk_pop;
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        acc_and_d = acc_and_q;
        acc_or_d  = acc_or_q;
        acc_xor_d = acc_xor_q;
        acc_pop_d = acc_pop_q;
        res_and_d = res_and_q;
        res_or_d  = res_or_q;
        res_xor_d = res_xor_q;
        res_pop_d = res_pop_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sr_d      = PAD_W'(in_data);
                    cnt_d     = '0;
                    acc_and_d = 1'b1;
                    acc_or_d  = 1'b0;
                    acc_xor_d = 1'b0;
                    acc_pop_d = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_and_d = fold_and;
                acc_or_d  = fold_or;
                acc_xor_d = fold_xor;
                acc_pop_d = fold_pop;
                sr_d      = sr_q >> CHUNK_WIDTH;
                cnt_d     = cnt_q + IDX_W'(1);
                if (last) begin
                    res_and_d = fold_and;
                    res_or_d  = fold_or;
                    res_xor_d = fold_xor;
                    res_pop_d = fold_pop;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            acc_and_q <= 1'b1;
            acc_or_q  <= 1'b0;
            acc_xor_q <= 1'b0;
            acc_pop_q <= '0;
            res_and_q <= 1'b1;
            res_or_q  <= 1'b0;
            res_xor_q <= 1'b0;
            res_pop_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            acc_and_q <= acc_and_d;
            acc_or_q  <= acc_or_d;
            acc_xor_q <= acc_xor_d;
            acc_pop_q <= acc_pop_d;
            res_and_q <= res_and_d;
            res_or_q  <= res_or_d;
            res_xor_q <= res_xor_d;
            res_pop_q <= res_pop_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_and      = res_and_q;
    assign out_or       = res_or_q;
    assign out_xor      = res_xor_q;
    assign out_popcount = res_pop_q;

endmodule

// File: tb/tb_reduction_stream_engine.sv
// Bench for reduction_stream_engine: several width/chunk configurations,
// each checked every cycle against a transaction-level reference model.
module tb_reduction_stream_engine;
    localparam int NI = 5;
    localparam int DWS [NI] = '{256, 100, 37, 256, 24};
    localparam int CWS [NI] = '{64, 64, 7, 256, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input int id, input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL u%0d %s: got %0d expected %0d", id, nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int DW = DWS[g];
        localparam int CW = CWS[g];
        localparam int NC = (DW + CW - 1) / CW;
        localparam int PW = $clog2(DW + 1);

        logic          rst_g = 1'b1;
        logic          iv    = 1'b0;
        logic          ordy  = 1'b0;
        logic [DW-1:0] din   = '0;
        logic          ir, ov, o_and, o_or, o_xor;
        logic [PW-1:0] o_pop;
        bit            fin = 1'b0;

        // Model: one outstanding operand, its age in cycles since accept,
        // and the result the outputs must currently show.
        bit            pend = 1'b0;
        int            age  = 0;
        logic [DW-1:0] cap  = '0;
        int            s_and = 1, s_or = 0, s_xor = 0, s_pop = 0;

        reduction_stream_engine #(
            .DATA_WIDTH (DW),
            .CHUNK_WIDTH(CW)
        ) u_dut (
            .clk         (clk),
            .rst         (rst_g),
            .in_valid    (iv),
            .in_ready    (ir),
            .in_data     (din),
            .out_valid   (ov),
            .out_ready   (ordy),
            .out_and     (o_and),
            .out_or      (o_or),
            .out_xor     (o_xor),
            .out_popcount(o_pop)
        );

        function automatic logic [DW-1:0] rnd_data();
            logic [255:0]  w;
            logic [DW-1:0] d;
            for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
            d = w[DW-1:0];
            case ($urandom % 4)
                0: d = '1;
                1: begin
                    d = '1;
                    d[$urandom % DW] = 1'b0;
                end
                default: ;
            endcase
            return d;
        endfunction

        task automatic cycle();
            if (rst_g) begin
                pend = 0; age = 0;
                s_and = 1; s_or = 0; s_xor = 0; s_pop = 0;
            end else if (!pend) begin
                if (iv) begin
                    pend = 1; age = 0; cap = din;
                end
            end else if (age >= NC) begin
                if (ordy) pend = 0;
            end else begin
                age++;
                if (age == NC) begin
                    s_and = int'(&cap);
                    s_or  = int'(|cap);
                    s_xor = int'(^cap);
                    s_pop = $countones(cap);
                end
            end
            @(posedge clk);
            @(negedge clk);
            chk(g, "in_ready", int'(ir), int'(!pend));
            chk(g, "out_valid", int'(ov), int'(pend && age >= NC));
            chk(g, "out_and", int'(o_and), s_and);
            chk(g, "out_or", int'(o_or), s_or);
            chk(g, "out_xor", int'(o_xor), s_xor);
            chk(g, "out_popcount", int'(o_pop), s_pop);
        endtask

        task automatic run_op(input logic [DW-1:0] d, input int hold);
            int lat = 0;
            rst_g = 1'b0; ordy = 1'b0; iv = 1'b1; din = d;
            cycle();
            iv = 1'b0; din = rnd_data();
            while (!ov && lat < NC + 4) begin
                cycle();
                lat++;
            end
            chk(g, "latency", lat, NC);
            repeat (hold) cycle();
            ordy = 1'b1;
            cycle();
            ordy = 1'b0;
        endtask

        initial begin
            logic [DW-1:0] d;
            repeat (2) cycle();
            rst_g = 1'b0;
            cycle();
            chk(g, "rst in_ready", int'(ir), 1);
            chk(g, "rst out_valid", int'(ov), 0);
            chk(g, "rst out_and", int'(o_and), 1);
            chk(g, "rst out_popcount", int'(o_pop), 0);

            run_op('1, 0);
            chk(g, "ones and", int'(o_and), 1);
            chk(g, "ones or", int'(o_or), 1);
            chk(g, "ones xor", int'(o_xor), DW % 2);
            chk(g, "ones pop", int'(o_pop), DW);

            d = '0;
            d[DW-1] = 1'b1;
            run_op(d, 0);
            chk(g, "msb and", int'(o_and), 0);
            chk(g, "msb or", int'(o_or), 1);
            chk(g, "msb xor", int'(o_xor), 1);
            chk(g, "msb pop", int'(o_pop), 1);

            run_op('0, 10);
            chk(g, "zero or", int'(o_or), 0);
            chk(g, "zero pop", int'(o_pop), 0);
            chk(g, "idle in_ready", int'(ir), 1);

            iv = 1'b1; din = '1;
            cycle();
            iv = 1'b0;
            cycle();
            rst_g = 1'b1;
            cycle();
            rst_g = 1'b0;
            chk(g, "midrst in_ready", int'(ir), 1);
            chk(g, "midrst out_valid", int'(ov), 0);
            chk(g, "midrst out_popcount", int'(o_pop), 0);
            repeat (NC + 3) cycle();
            chk(g, "midrst no result", int'(ov), 0);

            for (int i = 0; i < 6000; i++) begin
                rst_g = ($urandom % 400 == 0);
                iv    = $urandom % 2;
                ordy  = $urandom % 2;
                din   = rnd_data();
                cycle();
            end
            fin = 1'b1;
        end
    end

    initial begin
        int n = 0;
        while (!(gi[0].fin && gi[1].fin && gi[2].fin && gi[3].fin && gi[4].fin)
               && n < 50000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50000) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d cycles expected fewer", n);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
